// File: rtl/knn_local_sp_banked.sv
// Banked local scratchpad: one write port, one read port, NUM_BANKS address-interleaved banks,
// pipelined reads with a valid tag, and a zero-fill clear engine. Optional: KNN_SP_RD_BYPASS_EN.
module knn_local_sp_banked #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [AddressWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0]    wr_data,
    input  logic                    rd_en,
    input  logic [AddressWidth-1:0] rd_addr,
    output logic                    rd_valid,
    output logic [DataWidth-1:0]    rd_data
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = AddressWidth - BANK_BITS;
    localparam int ROWS      = AddressRange / NUM_BANKS;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        READY
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ROW_W-1:0]   clear_row;
    logic [ROW_W-1:0]   next_row;

    logic               wr_fire;
    logic               rd_fire;
    logic [BANK_W-1:0]  wr_bank;
    logic [BANK_W-1:0]  rd_bank;
    logic [ROW_W-1:0]   wr_row;
    logic [ROW_W-1:0]   rd_row;
    logic [DataWidth-1:0] bank_q [NUM_BANKS];
    logic [DataWidth-1:0] issue_data;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DataWidth-1:0]    pipe_data [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_row <= '0;
        end else begin
            state     <= next_state;
            clear_row <= next_row;
        end
    end

    // The reserved IDLE encoding behaves exactly like CLEAR.
    always_comb begin
        next_state = state;
        next_row   = clear_row;
        case (state)
            READY: begin
                if (clear_req) begin
                    next_state = CLEAR;
                    next_row   = '0;
                end
            end
            default: begin
                if (clear_row == LAST_ROW) begin
                    next_state = READY;
                    next_row   = '0;
                end else begin
                    next_state = CLEAR;
                    next_row   = clear_row + 1'b1;
                end
            end
        endcase
    end

    assign busy    = (state != READY);
    assign wr_fire = wr_en && !busy && !reset;
    assign rd_fire = rd_en && !busy;
    assign wr_row  = wr_addr[AddressWidth-1:BANK_BITS];
    assign rd_row  = rd_addr[AddressWidth-1:BANK_BITS];

    generate
        if (NUM_BANKS > 1) begin : g_bank_sel
            assign wr_bank = wr_addr[BANK_BITS-1:0];
            assign rd_bank = rd_addr[BANK_BITS-1:0];
        end else begin : g_single_bank
            assign wr_bank = '0;
            assign rd_bank = '0;
        end
    endgenerate

    // While clearing, every bank zeroes the same row; user writes are locked out.
    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DataWidth-1:0] mem [ROWS];

            always_ff @(posedge clk) begin
                if (busy) begin
                    mem[clear_row] <= '0;
                end else if (wr_fire && (wr_bank == BANK_W'(b))) begin
                    mem[wr_row] <= wr_data;
                end
            end

            assign bank_q[b] = mem[rd_row];
        end
    endgenerate

`ifdef KNN_SP_RD_BYPASS_EN
    assign issue_data = (wr_fire && (wr_addr == rd_addr)) ? wr_data : bank_q[rd_bank];
`else
    assign issue_data = bank_q[rd_bank];
`endif

    // Stage 0 captures the array word; later stages only move data alongside its valid bit,
    // so the output word holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data[0] <= issue_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign rd_valid = pipe_valid[READ_LATENCY-1];
    assign rd_data  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_knn_local_sp_banked.sv
// Directed bench for knn_local_sp_banked; runs a READ_LATENCY=2 and a READ_LATENCY=4 instance in lockstep.
module tb_knn_local_sp_banked;

    localparam int AW = 11;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          busy, busy4;
    logic          rd_valid, rd_valid4;
    logic [DW-1:0] rd_data, rd_data4;

    int checks = 0;
    int failures = 0;

    knn_local_sp_banked #(.READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    knn_local_sp_banked #(.READ_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid4), .rd_data(rd_data4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Issues one read (optionally with a same-cycle write to the same address) and records,
    // for each instance, the cycle offset of the first rd_valid, its data and the pulse count.
    task automatic read_both(input logic [AW-1:0] a, input bit with_wr, input logic [DW-1:0] wd,
                             output logic [DW-1:0] d2, output logic [DW-1:0] d4,
                             output int lat2, output int lat4, output int cnt2, output int cnt4);
        d2 = '0; d4 = '0; lat2 = -1; lat4 = -1; cnt2 = 0; cnt4 = 0;
        rd_en   = 1'b1;
        rd_addr = a;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = wd;
        end
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (rd_valid) begin
                cnt2++;
                if (lat2 < 0) begin lat2 = c; d2 = rd_data; end
            end
            if (rd_valid4) begin
                cnt4++;
                if (lat4 < 0) begin lat4 = c; d4 = rd_data4; end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d2, d4;
        int lat2, lat4, cnt2, cnt4, n;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (rd_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid4: got %b expected 0", rd_valid4); end
        checks++; if (rd_data4 !== '0) begin failures++; $display("[TB] FAIL reset_rd_data4: got %h expected 0", rd_data4); end
        reset = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        checks++; if (n !== 512) begin failures++; $display("[TB] FAIL reset_clear_cycles: got %0d expected 512", n); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy4_fall: got %b expected 0", busy4); end
        read_both(11'd2047, 1'b0, '0, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (lat2 !== 2) begin failures++; $display("[TB] FAIL a2047_latency: got %0d expected 2", lat2); end
        checks++; if (d2 !== '0) begin failures++; $display("[TB] FAIL a2047_data: got %h expected 0", d2); end
        checks++; if (lat4 !== 4) begin failures++; $display("[TB] FAIL a2047_latency4: got %0d expected 4", lat4); end
        checks++; if (d4 !== '0) begin failures++; $display("[TB] FAIL a2047_data4: got %h expected 0", d4); end
        checks++; if (cnt2 !== 1) begin failures++; $display("[TB] FAIL a2047_pulses: got %0d expected 1", cnt2); end
        checks++; if (cnt4 !== 1) begin failures++; $display("[TB] FAIL a2047_pulses4: got %0d expected 1", cnt4); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d2, d4, pat;
        int lat2, lat4, cnt2, cnt4;
        pat = {32{8'hA5}};
        write_word(11'd5, pat);
        read_both(11'd5, 1'b0, '0, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (lat2 !== 2) begin failures++; $display("[TB] FAIL wr5_latency: got %0d expected 2", lat2); end
        checks++; if (d2 !== pat) begin failures++; $display("[TB] FAIL wr5_data: got %h expected %h", d2, pat); end
        checks++; if (lat4 !== 4) begin failures++; $display("[TB] FAIL wr5_latency4: got %0d expected 4", lat4); end
        checks++; if (d4 !== pat) begin failures++; $display("[TB] FAIL wr5_data4: got %h expected %h", d4, pat); end
        checks++; if (cnt2 !== 1) begin failures++; $display("[TB] FAIL wr5_pulses: got %0d expected 1", cnt2); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL wr5_valid_after: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== pat) begin failures++; $display("[TB] FAIL wr5_hold: got %h expected %h", rd_data, pat); end
        checks++; if (rd_data4 !== pat) begin failures++; $display("[TB] FAIL wr5_hold4: got %h expected %h", rd_data4, pat); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d2, d4, old_word, new_word, exp_word;
        int lat2, lat4, cnt2, cnt4;
        old_word = {224'd0, 32'h0000_0077};
        new_word = {224'd0, 32'h0000_1234};
`ifdef KNN_SP_RD_BYPASS_EN
        exp_word = new_word;
`else
        exp_word = old_word;
`endif
        write_word(11'd9, old_word);
        read_both(11'd9, 1'b1, new_word, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (d2 !== exp_word) begin failures++; $display("[TB] FAIL collide_data: got %h expected %h", d2, exp_word); end
        checks++; if (d4 !== exp_word) begin failures++; $display("[TB] FAIL collide_data4: got %h expected %h", d4, exp_word); end
        checks++; if (lat2 !== 2) begin failures++; $display("[TB] FAIL collide_latency: got %0d expected 2", lat2); end
        read_both(11'd9, 1'b0, '0, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (d2 !== new_word) begin failures++; $display("[TB] FAIL collide_after: got %h expected %h", d2, new_word); end
        checks++; if (d4 !== new_word) begin failures++; $display("[TB] FAIL collide_after4: got %h expected %h", d4, new_word); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_words [16];
        int n2, n4, first2, first4, last2, last4;
        for (int i = 0; i < 16; i++) begin
            exp_words[i] = {8{32'hB0B0_0000 + 32'(i)}};
            write_word(11'(i), exp_words[i]);
        end
        n2 = 0; n4 = 0; first2 = -1; first4 = -1; last2 = -1; last4 = -1;
        for (int c = 0; c < 24; c++) begin
            rd_en   = (c < 16);
            rd_addr = 11'(c);
            tick();
            if (rd_valid) begin
                if (n2 == 0) first2 = c;
                last2 = c;
                if (n2 < 16) begin
                    checks++;
                    if (rd_data !== exp_words[n2]) begin
                        failures++;
                        $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", n2, rd_data, exp_words[n2]);
                    end
                end
                n2++;
            end
            if (rd_valid4) begin
                if (n4 == 0) first4 = c;
                last4 = c;
                if (n4 < 16) begin
                    checks++;
                    if (rd_data4 !== exp_words[n4]) begin
                        failures++;
                        $display("[TB] FAIL b2b_data4[%0d]: got %h expected %h", n4, rd_data4, exp_words[n4]);
                    end
                end
                n4++;
            end
        end
        rd_en = 1'b0;
        checks++; if (n2 !== 16) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 16", n2); end
        checks++; if (first2 !== 1) begin failures++; $display("[TB] FAIL b2b_first: got %0d expected 1", first2); end
        checks++; if (last2 !== 16) begin failures++; $display("[TB] FAIL b2b_last: got %0d expected 16", last2); end
        checks++; if (n4 !== 16) begin failures++; $display("[TB] FAIL b2b_count4: got %0d expected 16", n4); end
        checks++; if (first4 !== 3) begin failures++; $display("[TB] FAIL b2b_first4: got %0d expected 3", first4); end
        checks++; if (last4 !== 18) begin failures++; $display("[TB] FAIL b2b_last4: got %0d expected 18", last4); end
    endtask

    task automatic test_clear_busy();
        logic [DW-1:0] d2, d4;
        int lat2, lat4, cnt2, cnt4, n, v2, v4;
        write_word(11'd100, '1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL clear_busy_rise: got %b expected 1", busy); end
        wr_en   = 1'b1;
        wr_addr = 11'd5;
        wr_data = {8{32'hDEAD_BEEF}};
        rd_en   = 1'b1;
        rd_addr = 11'd5;
        n = 0; v2 = 0; v4 = 0;
        while (busy && n < 2000) begin
            if (rd_valid) v2++;
            if (rd_valid4) v4++;
            tick();
            n++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rd_valid) v2++;
            if (rd_valid4) v4++;
            tick();
        end
        checks++; if (n !== 512) begin failures++; $display("[TB] FAIL clear_cycles: got %0d expected 512", n); end
        checks++; if (v2 !== 0) begin failures++; $display("[TB] FAIL clear_no_valid: got %0d expected 0", v2); end
        checks++; if (v4 !== 0) begin failures++; $display("[TB] FAIL clear_no_valid4: got %0d expected 0", v4); end
        read_both(11'd100, 1'b0, '0, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (d2 !== '0) begin failures++; $display("[TB] FAIL clear_a100: got %h expected 0", d2); end
        checks++; if (lat2 !== 2) begin failures++; $display("[TB] FAIL clear_a100_latency: got %0d expected 2", lat2); end
        read_both(11'd5, 1'b0, '0, d2, d4, lat2, lat4, cnt2, cnt4);
        checks++; if (d2 !== '0) begin failures++; $display("[TB] FAIL clear_a5_blocked_write: got %h expected 0", d2); end
        checks++; if (d4 !== '0) begin failures++; $display("[TB] FAIL clear_a5_blocked_write4: got %h expected 0", d4); end
    endtask

    task automatic test_reset_mid_clear();
        int n, v;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 11'd7;
        v = 0;
        for (int c = 1; c < 200; c++) begin
            if (rd_valid || rd_valid4) v++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 1", busy); end
        checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL midrst_rd_data: got %h expected 0", rd_data); end
        n = 0;
        while (busy && n < 2000) begin
            if (rd_valid || rd_valid4) v++;
            tick();
            n++;
        end
        rd_en = 1'b0;
        checks++; if (n !== 512) begin failures++; $display("[TB] FAIL midrst_clear_cycles: got %0d expected 512", n); end
        checks++; if (v !== 0) begin failures++; $display("[TB] FAIL midrst_no_valid: got %0d expected 0", v); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clear_busy();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
